rx_frame_ctrl: RTL

Receive-side frame sequencer that sits ahead of the mixed-mode depacketizer in the PSK receive chain. It arms preamble detection, then Barker detection. It hands the depacketizer a single start pulse and the latched Barker polarity, and watches the depacketizer's AXIS output for end-of-frame. It recovers from missed or runaway frames with timeouts and a depacketizer flush, and keeps frame and timeout statistics.

---
 rtl/rx_frame_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: arms preamble then Barker detection, starts the depacketizer,
// watches AXIS tlast for end-of-frame, and recovers from stalls with timeouts and a flush.
`timescale 1ns/1ps
module rx_frame_ctrl #(
    parameter int unsigned BD_TIMEOUT    = 1024,
    parameter int unsigned FRAME_TIMEOUT = 65535,
    parameter int unsigned HOLDOFF       = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [3:0]           MODE_CTRL,
    input  logic                 PD_flag,
    input  logic                 BD_flag,
    input  logic                 BD_sgn,
    input  logic                 data_tvalid,
    input  logic                 data_tready,
    input  logic                 data_tlast,
    output logic                 PD_en,
    output logic                 BD_en,
    output logic                 bd_start,
    output logic                 bd_sgn_out,
    output logic                 dp_rst,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] timeout_cnt
);

    typedef enum logic [5:0] {
        StIdle   = 6'b000001,
        StPdWait = 6'b000010,
        StBdWait = 6'b000100,
        StActive = 6'b001000,
        StFlush  = 6'b010000,
        StHold   = 6'b100000
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        armed;
    logic        bd_accept;
    logic        eof_hit;
    logic        to_hit;

    assign armed = enable && (MODE_CTRL == 4'b0100);

    always_comb begin
        state_d   = state_q;
        bd_accept = 1'b0;
        eof_hit   = 1'b0;
        to_hit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed) state_d = StPdWait;
            end
            StPdWait: begin
                if (!armed)       state_d = StFlush;
                else if (PD_flag) state_d = StBdWait;
            end
            StBdWait: begin
                if (!armed) begin
                    state_d = StFlush;
                end else if (BD_flag) begin
                    state_d   = StActive;
                    bd_accept = 1'b1;
                end else if (timer_q == BD_TIMEOUT - 1) begin
                    state_d = StFlush;
                    to_hit  = 1'b1;
                end
            end
            StActive: begin
                if (!armed) begin
                    state_d = StFlush;
                end else if (data_tvalid && data_tready && data_tlast) begin
                    state_d = StHold;
                    eof_hit = 1'b1;
                end else if (timer_q == FRAME_TIMEOUT - 1) begin
                    state_d = StFlush;
                    to_hit  = 1'b1;
                end
            end
            StFlush: begin
                state_d = StHold;
            end
            StHold: begin
                if (timer_q == HOLDOFF - 1) state_d = armed ? StPdWait : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Timer restarts from zero whenever a new state is entered.
        timer_d = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= 32'd0;
            PD_en       <= 1'b0;
            BD_en       <= 1'b0;
            bd_start    <= 1'b0;
            bd_sgn_out  <= 1'b0;
            dp_rst      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout     <= 1'b0;
            frame_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            // Level outputs trail the state register by one cycle.
            PD_en      <= (state_q == StPdWait);
            BD_en      <= (state_q == StBdWait);
            busy       <= (state_q != StIdle);
            dp_rst     <= (state_q == StFlush);
            bd_start   <= bd_accept;
            frame_done <= eof_hit;
            timeout    <= to_hit;
            if (bd_accept) bd_sgn_out <= BD_sgn;
            if (eof_hit && (frame_cnt != '1)) frame_cnt <= frame_cnt + CntOne;
            if (to_hit && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + CntOne;
        end
    end

endmodule
